// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks registers awaiting load data and stalls
// decode on RAW/WAW hazards or when too many loads are in flight.
module hazard_scoreboard #(
    parameter int unsigned RegAddrWidth  = 5,
    parameter int unsigned MaxPending    = 4,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Issue_valid,
    input  logic                    Issue_is_load,
    input  logic                    Issue_reg_write,
    input  logic [RegAddrWidth-1:0] Issue_rd,
    input  logic [RegAddrWidth-1:0] IF_ID_RS1,
    input  logic [RegAddrWidth-1:0] IF_ID_RS2,
    input  logic                    Use_RS1,
    input  logic                    Use_RS2,
    input  logic                    Load_done_valid,
    input  logic [RegAddrWidth-1:0] Load_done_rd,
    output logic                    Stall_decode,
    output logic                    Bubble_execute,
    output logic [RegAddrWidth-1:0] Pending_count,
    output logic                    Stall_timeout,
    output logic                    Done_error
);

    localparam int unsigned NumRegs  = 2 ** RegAddrWidth;
    localparam int unsigned CntWidth = 8;

    localparam logic [RegAddrWidth-1:0] MaxPendingVal = RegAddrWidth'(MaxPending);
    localparam logic [CntWidth-1:0]     TimeoutVal    = CntWidth'(TimeoutCycles);
    localparam logic [CntWidth-1:0]     CntMax        = '1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_n;
    logic [NumRegs-1:0]      busy_q;
    logic [NumRegs-1:0]      busy_n;
    logic [CntWidth-1:0]     stall_cnt_q;
    logic [CntWidth-1:0]     stall_cnt_n;
    logic [RegAddrWidth-1:0] pending_n;
    logic                    timeout_n;
    logic                    done_err_n;

    logic [NumRegs-1:0]      release_vec;
    logic [NumRegs-1:0]      busy_eff;
    logic                    clr_hit;
    logic                    set_hit;
    logic                    issue_fire;
    logic [RegAddrWidth-1:0] pending_eff;
    logic                    raw_rs1;
    logic                    raw_rs2;
    logic                    waw_rd;
    logic                    cap_full;

    // Hazard detection; a completing load releases its register in the same cycle
    always_comb begin
        release_vec  = '0;
        busy_eff     = busy_q;
        clr_hit      = 1'b0;
        pending_eff  = Pending_count;
        raw_rs1      = 1'b0;
        raw_rs2      = 1'b0;
        waw_rd       = 1'b0;
        cap_full     = 1'b0;
        Stall_decode = 1'b0;

        if (Load_done_valid) begin
            release_vec[Load_done_rd] = 1'b1;
        end
        busy_eff    = busy_q & ~release_vec;
        clr_hit     = Load_done_valid & busy_q[Load_done_rd];
        pending_eff = Pending_count - RegAddrWidth'(clr_hit);

        raw_rs1  = Use_RS1 & busy_eff[IF_ID_RS1];
        raw_rs2  = Use_RS2 & busy_eff[IF_ID_RS2];
        waw_rd   = Issue_reg_write & busy_eff[Issue_rd];
        cap_full = Issue_is_load & (pending_eff == MaxPendingVal);

        Stall_decode = Issue_valid & (raw_rs1 | raw_rs2 | waw_rd | cap_full);
    end

    assign Bubble_execute = Stall_decode;
    assign issue_fire     = Issue_valid & ~Stall_decode;
    assign set_hit        = issue_fire & Issue_is_load & Issue_reg_write & (Issue_rd != '0);

    // Next-state: RUN/STALL FSM, stall counter, busy bits, pending count
    always_comb begin
        state_n     = state_q;
        stall_cnt_n = stall_cnt_q;
        busy_n      = busy_q;
        pending_n   = Pending_count;
        timeout_n   = Stall_timeout;
        done_err_n  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (Stall_decode) begin
                    state_n     = ST_STALL;
                    stall_cnt_n = CntWidth'(1);
                end else begin
                    stall_cnt_n = '0;
                end
            end
            ST_STALL: begin
                if (Stall_decode) begin
                    stall_cnt_n = (stall_cnt_q == CntMax) ? stall_cnt_q
                                                          : stall_cnt_q + CntWidth'(1);
                end else begin
                    state_n     = ST_RUN;
                    stall_cnt_n = '0;
                end
            end
            default: begin
                state_n     = ST_RUN;
                stall_cnt_n = '0;
            end
        endcase

        if (stall_cnt_n >= TimeoutVal) begin
            timeout_n = 1'b1;
        end

        // Clear first so a same-cycle reissue to the same register wins
        if (clr_hit) begin
            busy_n[Load_done_rd] = 1'b0;
        end
        if (set_hit) begin
            busy_n[Issue_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;

        pending_n = Pending_count + RegAddrWidth'(set_hit) - RegAddrWidth'(clr_hit);

        done_err_n = Load_done_valid & ~busy_q[Load_done_rd];
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= '0;
            busy_q        <= '0;
            Pending_count <= '0;
            Stall_timeout <= 1'b0;
            Done_error    <= 1'b0;
        end else begin
            state_q       <= state_n;
            stall_cnt_q   <= stall_cnt_n;
            busy_q        <= busy_n;
            Pending_count <= pending_n;
            Stall_timeout <= timeout_n;
            Done_error    <= done_err_n;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a register-array reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_hazard_scoreboard;

    localparam int unsigned AW   = 5;
    localparam int unsigned MAXP = 4;
    localparam int unsigned TMO  = 3;
    localparam int unsigned NREG = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Issue_valid = 1'b0;
    logic          Issue_is_load = 1'b0;
    logic          Issue_reg_write = 1'b0;
    logic [AW-1:0] Issue_rd = '0;
    logic [AW-1:0] IF_ID_RS1 = '0;
    logic [AW-1:0] IF_ID_RS2 = '0;
    logic          Use_RS1 = 1'b0;
    logic          Use_RS2 = 1'b0;
    logic          Load_done_valid = 1'b0;
    logic [AW-1:0] Load_done_rd = '0;
    logic          Stall_decode;
    logic          Bubble_execute;
    logic [AW-1:0] Pending_count;
    logic          Stall_timeout;
    logic          Done_error;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .RegAddrWidth (AW),
        .MaxPending   (MAXP),
        .TimeoutCycles(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Issue_valid    (Issue_valid),
        .Issue_is_load  (Issue_is_load),
        .Issue_reg_write(Issue_reg_write),
        .Issue_rd       (Issue_rd),
        .IF_ID_RS1      (IF_ID_RS1),
        .IF_ID_RS2      (IF_ID_RS2),
        .Use_RS1        (Use_RS1),
        .Use_RS2        (Use_RS2),
        .Load_done_valid(Load_done_valid),
        .Load_done_rd   (Load_done_rd),
        .Stall_decode   (Stall_decode),
        .Bubble_execute (Bubble_execute),
        .Pending_count  (Pending_count),
        .Stall_timeout  (Stall_timeout),
        .Done_error     (Done_error)
    );

    typedef struct {
        bit stall;
        int pend;
        bit tmo;
        bit err;
    } exp_t;

    exp_t q[$];

    // Reference model state
    bit mbusy[NREG];
    int mrun;
    bit mtmo;
    bit merr;
    bit mvalid;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle with a prediction, compare all outputs mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("stall_decode",   32'(Stall_decode),   32'(e.stall));
            check("bubble_execute", 32'(Bubble_execute), 32'(e.stall));
            check("pending_count",  32'(Pending_count),  32'(e.pend));
            check("stall_timeout",  32'(Stall_timeout),  32'(e.tmo));
            check("done_error",     32'(Done_error),     32'(e.err));
        end
    end

    // Drive one cycle of stimulus, predict its outputs, then advance the model
    task automatic step(input bit rst, input bit iv, input bit ld, input bit wr, input int rd,
                        input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit dv, input int drd);
        bit   bz[NREG];
        int   eff;
        int   cnt;
        bit   stall;
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        Issue_valid     = iv;
        Issue_is_load   = ld;
        Issue_reg_write = wr;
        Issue_rd        = AW'(rd);
        IF_ID_RS1       = AW'(rs1);
        IF_ID_RS2       = AW'(rs2);
        Use_RS1         = u1;
        Use_RS2         = u2;
        Load_done_valid = dv;
        Load_done_rd    = AW'(drd);

        eff = 0;
        cnt = 0;
        for (int r = 0; r < NREG; r++) begin
            bz[r] = mbusy[r] && !(dv && drd == r);
            eff += int'(bz[r]);
            cnt += int'(mbusy[r]);
        end
        stall = iv && ((u1 && bz[rs1]) || (u2 && bz[rs2]) || (wr && bz[rd]) ||
                       (ld && eff == MAXP));
        if (mvalid) begin
            e.stall = stall;
            e.pend  = cnt;
            e.tmo   = mtmo;
            e.err   = merr;
            q.push_back(e);
        end

        if (rst) begin
            for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
            mrun   = 0;
            mtmo   = 1'b0;
            merr   = 1'b0;
            mvalid = 1'b1;
        end else begin
            merr = dv && !mbusy[drd];
            if (dv) mbusy[drd] = 1'b0;
            if (iv && !stall && ld && wr && rd != 0) mbusy[rd] = 1'b1;
            mrun = stall ? ((mrun < 255) ? mrun + 1 : 255) : 0;
            if (mrun >= TMO) mtmo = 1'b1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int rd);
        step(0, 1, 1, 1, rd, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read1(input int rs);
        step(0, 1, 0, 1, 10, rs, 1, 0, 0, 0, 0);
    endtask

    task automatic done(input int rd);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        do_reset();

        // Load-use stall released by same-cycle completion
        load(5);
        read1(5);
        step(0, 1, 0, 1, 10, 5, 1, 0, 0, 1, 5);
        idle();

        // Capacity limit with same-cycle completion freeing a slot
        do_reset();
        load(1); load(2); load(3); load(4);
        load(6);
        load(6);
        step(0, 1, 1, 1, 6, 0, 0, 0, 0, 1, 2);
        idle();
        read1(6);
        step(0, 1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        idle();

        // Same-register completion and reissue: bit stays set
        do_reset();
        load(7);
        step(0, 1, 1, 1, 7, 0, 0, 0, 0, 1, 7);
        read1(7);
        idle();

        // Completion for idle register and loads to x0
        do_reset();
        done(9);
        idle();
        idle();
        load(0);
        read1(0);
        step(0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0);
        idle();

        // Stall timeout is sticky until reset
        do_reset();
        load(3);
        repeat (5) read1(3);
        step(0, 1, 0, 1, 10, 3, 1, 0, 0, 1, 3);
        idle();
        idle();
        do_reset();
        idle();

        // Reset mid-stall drops hazards; later completions are errors
        load(1);
        load(2);
        read1(1);
        step(1, 1, 0, 1, 10, 1, 1, 0, 0, 0, 0);
        idle();
        step(0, 1, 0, 1, 10, 1, 1, 2, 1, 0, 0);
        done(1);
        idle();

        // Randomized traffic over a small register window
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bit rst_r;
            rst_r = ($urandom_range(0, 99) < 2);
            step(rst_r,
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 8),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 4),
                 int'($urandom_range(0, 7)));
        end
        idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter RegAddrWidth, default 5, register address width (2**RegAddrWidth architectural registers).
REQ-002 SHALL have parameter MaxPending, default 4, maximum loads in flight (1..2**RegAddrWidth-1).
REQ-003 SHALL have parameter TimeoutCycles, default 255, consecutive stall cycles before timeout flag (1..255).
REQ-004 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have Issue_valid  input  1  decode-stage instruction presented for issue.
REQ-007 SHALL have Issue_is_load  input  1  presented instruction is a load.
REQ-008 SHALL have Issue_reg_write  input  1  presented instruction writes the register file.
REQ-009 SHALL have Issue_rd  input  RegAddrWidth  destination register of presented instruction.
REQ-010 SHALL have IF_ID_RS1 / IF_ID_RS2  input  RegAddrWidth each  source registers of presented instruction.
REQ-011 SHALL have Use_RS1 / Use_RS2  input  1 each  instruction actually reads that source.
REQ-012 SHALL have Load_done_valid  input  1  memory stage returns load data this cycle.
REQ-013 SHALL have Load_done_rd  input  RegAddrWidth  destination of the returning load.
REQ-014 SHALL have Stall_decode  output  1  hold IF/ID and PC this cycle.
REQ-015 SHALL have Bubble_execute  output  1  inject NOP into ID/EX this cycle.
REQ-016 SHALL have Pending_count  output  RegAddrWidth  number of busy registers.
REQ-017 SHALL have Stall_timeout  output  1  sticky flag, stall exceeded TimeoutCycles.
REQ-018 SHALL have Done_error  output  1  one-cycle registered pulse, load completion for non-busy register.

Function
REQ-019 SHALL hold a busy bit per register; register 0 never busy.
REQ-020 SHALL assert Stall_decode combinationally when Issue_valid and any of: Use_RS1 with busy[IF_ID_RS1]; Use_RS2 with busy[IF_ID_RS2]; Issue_reg_write with busy[Issue_rd] (WAW); Issue_is_load with Pending_count == MaxPending.
REQ-021 SHALL treat a hazard as cleared in the same cycle Load_done_valid names that register (completion bypasses stall; zero-cycle release).
REQ-022 SHALL drive Bubble_execute equal to Stall_decode.
REQ-023 SHALL define issue_fire = Issue_valid && !Stall_decode.
REQ-024 SHALL set busy[Issue_rd] at the clock edge when issue_fire, Issue_is_load, Issue_reg_write, Issue_rd != 0.
REQ-025 SHALL clear busy[Load_done_rd] at the edge when Load_done_valid and that bit is busy.
REQ-026 SHALL, on set and clear of the same register in one cycle, leave the bit set (new load wins), Pending_count unchanged.
REQ-027 SHALL increment Pending_count on set only, decrement on clear only, hold on set+clear of different registers; never wrap.
REQ-028 SHALL pulse Done_error for one cycle after Load_done_valid with non-busy or zero Load_done_rd; scoreboard unchanged.
REQ-029 SHALL implement FSM RUN/STALL: RUN->STALL on Stall_decode; STALL->RUN on !Stall_decode; stall counter cleared in RUN, incremented per STALL cycle, saturating at 255.
REQ-030 SHALL set Stall_timeout when the counter reaches TimeoutCycles; stays set until reset.
REQ-031 SHALL not stall when Issue_valid is low; FSM returns to RUN.

Reset
REQ-032 SHALL, with reset high at an edge, clear all busy bits, Pending_count=0, FSM=RUN, counter=0, Stall_timeout=0, Done_error=0; Stall_decode and Bubble_execute low thereafter until new hazard.
REQ-033 SHALL discard loads in flight on reset; their later completions produce Done_error.

Verification
REQ-034 Load to x5 fires; next cycle add reads x5 (Use_RS1) -> Stall_decode=1, Bubble_execute=1, Pending_count=1; Load_done x5 -> stall drops same cycle, Pending_count=0 next edge.
REQ-035 MaxPending=4 loads to x1..x4 fire; fifth load to x6 -> stall until any completion; same-cycle Load_done x2 -> fifth fires, Pending_count stays 4.
REQ-036 Load x7 busy; same cycle Load_done x7 and new load x7 fires -> busy[x7]=1, Pending_count=1.
REQ-037 Load_done x9 with x9 idle -> Done_error=1 for exactly one cycle, Pending_count unchanged; load to x0 -> no busy bit, no stall on x0 reads.
REQ-038 TimeoutCycles=3, held stall on busy x3 -> Stall_timeout rises after third STALL cycle, stays high after release until reset.
REQ-039 Reset asserted mid-stall with Pending_count=2 -> next cycle all outputs zero, prior hazards gone.
